muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the execute stage of the pipelined risc_v core. It accepts one MUL/DIV/REM operation, computes one result bit per cycle, and drives Busy so the hazard path stalls fetch, decode and execute while it works. Divide-by-zero and signed overflow are handled on a single-cycle fast path. An execute-stage flush aborts the operation in progress.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit for the execute stage
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   StartE     launch request, sampled only in IDLE
//   MulDivOpE  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   SrcAE      rs1 operand (multiplicand / dividend)
//   SrcBE      rs2 operand (multiplier / divisor)
//   FlushE     abort, has priority over StartE
//   BusyE      stall request to the hazard path
//   DoneE      one-cycle pulse, ResultE valid in this cycle
//   ResultE    result, held until the next accepted start
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StartE,
  input  logic [2:0]            MulDivOpE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic                  FlushE,
  output logic                  BusyE,
  output logic                  DoneE,
  output logic [DATA_WIDTH-1:0] ResultE
);

  localparam int W = DATA_WIDTH;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [W-1:0]         MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  // Latched operation: op, result sign, operand B magnitude (multiplicand or
  // divisor), product register, partial remainder and dividend/quotient shifter.
  logic [2:0]           op;
  logic                 neg;
  logic [W-1:0]         b_mag;
  logic [2*W-1:0]       prod;
  logic [W-1:0]         rem;
  logic [W-1:0]         quot;
  logic [CNT_WIDTH-1:0] cnt;

  // Acceptance-time decode
  logic         accept, is_div, a_signed, b_signed, sgn_a, sgn_b, neg_in;
  logic         div_zero, div_ovf, fast;
  logic [W-1:0] a_mag_in, b_mag_in, fast_result;

  assign accept   = (state == IDLE) & StartE & ~FlushE;
  assign is_div   = MulDivOpE[2];
  assign a_signed = (MulDivOpE == OP_MULH) | (MulDivOpE == OP_MULHSU) |
                    (MulDivOpE == OP_DIV)  | (MulDivOpE == OP_REM);
  assign b_signed = (MulDivOpE == OP_MULH) | (MulDivOpE == OP_DIV) | (MulDivOpE == OP_REM);
  assign sgn_a    = a_signed & SrcAE[W-1];
  assign sgn_b    = b_signed & SrcBE[W-1];
  assign a_mag_in = sgn_a ? -SrcAE : SrcAE;
  assign b_mag_in = sgn_b ? -SrcBE : SrcBE;
  // Remainder follows the dividend sign; product and quotient follow sgnA^sgnB.
  assign neg_in   = (is_div & MulDivOpE[1]) ? sgn_a : (sgn_a ^ sgn_b);

  // Divide-by-zero and signed overflow never enter CALC.
  assign div_zero    = is_div & (SrcBE == '0);
  assign div_ovf     = is_div & ~MulDivOpE[0] & (SrcAE == MIN_NEG) & (SrcBE == '1);
  assign fast        = div_zero | div_ovf;
  assign fast_result = div_zero ? (MulDivOpE[1] ? SrcAE : '1)
                                : (MulDivOpE[1] ? '0    : SrcAE);

  // One iteration of shift-add multiply and restoring divide
  logic [W:0]     mul_sum, trial;
  logic [2*W-1:0] prod_step, prod_signed;
  logic [W-1:0]   rem_step, quot_step, div_mag, final_result;

  assign mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, b_mag};
  assign prod_step = prod[0] ? {mul_sum, prod[W-1:1]} : {1'b0, prod[2*W-1:1]};

  // trial[W] set means the shifted remainder is below the divisor: restore.
  assign trial     = {rem, quot[W-1]} - {1'b0, b_mag};
  assign rem_step  = trial[W] ? {rem[W-2:0], quot[W-1]} : trial[W-1:0];
  assign quot_step = {quot[W-2:0], ~trial[W]};

  // Negate the full double-width product so the high half is correct.
  assign prod_signed  = neg ? -prod_step : prod_step;
  assign div_mag      = op[1] ? rem_step : quot_step;
  assign final_result = op[2] ? (neg ? -div_mag : div_mag)
                              : ((op == OP_MUL) ? prod_signed[W-1:0] : prod_signed[2*W-1:W]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    BusyE      = 1'b0;
    DoneE      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          BusyE      = 1'b1;
          state_next = fast ? DONE : CALC;
        end
      end
      CALC: begin
        BusyE = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        DoneE      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (FlushE) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= '0;
      neg     <= 1'b0;
      b_mag   <= '0;
      prod    <= '0;
      rem     <= '0;
      quot    <= '0;
      cnt     <= '0;
      ResultE <= '0;
    end else if (FlushE) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (StartE) begin
            op    <= MulDivOpE;
            neg   <= neg_in;
            b_mag <= b_mag_in;
            prod  <= {{W{1'b0}}, a_mag_in};
            rem   <= '0;
            quot  <= a_mag_in;
            cnt   <= fast ? '0 : CNT_LAST;
            if (fast) ResultE <= fast_result;
          end
        end
        CALC: begin
          prod <= prod_step;
          rem  <= rem_step;
          quot <= quot_step;
          if (cnt == '0) ResultE <= final_result;
          else           cnt     <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        StartE;
  logic        FlushE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        BusyE;
  logic        DoneE;
  logic [31:0] ResultE;

  int checks   = 0;
  int failures = 0;

  int          done_cnt, done_at, busy_cnt;
  logic [31:0] got_res, prev_res;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .StartE    (StartE),
    .MulDivOpE (MulDivOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .FlushE    (FlushE),
    .BusyE     (BusyE),
    .DoneE     (DoneE),
    .ResultE   (ResultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics with 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Launch one operation, scribble StartE/operands while it runs, and check
  // latency, busy cycles, single done pulse and result hold.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res, res;
    int          exp_done, dcnt, dat, bcnt;
    bit          fast;
    exp_res  = ref_op(op, a, b);
    fast     = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_done = fast ? 1 : 33;
    @(negedge clk);
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b;
    #1;
    check({tag, " busy_at_start"}, 32'(BusyE), 32'd1);
    dcnt = 0; dat = 0; bcnt = 0; res = '0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k <= exp_done) begin
        StartE    = 1'($urandom_range(0, 1));
        MulDivOpE = 3'($urandom_range(0, 7));
        SrcAE     = $urandom;
        SrcBE     = $urandom;
      end else begin
        StartE = 1'b0;
      end
      #1;
      if (BusyE) bcnt++;
      if (DoneE) begin
        dcnt++;
        if (dat == 0) begin dat = k; res = ResultE; end
      end
    end
    check({tag, " done_count"}, 32'(dcnt), 32'd1);
    check({tag, " done_cycle"}, 32'(dat), 32'(exp_done));
    check({tag, " busy_cycles"}, 32'(bcnt), fast ? 32'd0 : 32'd32);
    check({tag, " result"}, res, exp_res);
    check({tag, " result_held"}, ResultE, exp_res);
  endtask

  initial begin
    rst = 1'b1; StartE = 1'b0; FlushE = 1'b0; MulDivOpE = '0; SrcAE = '0; SrcBE = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", 32'(BusyE), 32'd0);
    check("reset_done", 32'(DoneE), 32'd0);
    check("reset_result", ResultE, 32'd0);

    // StartE and FlushE together in IDLE: nothing launches
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b1; MulDivOpE = 3'd5; SrcAE = 32'd100; SrcBE = 32'd7;
    #1;
    check("startflush_busy", 32'(BusyE), 32'd0);
    done_cnt = 0; busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      StartE = 1'b0; FlushE = 1'b0;
      #1;
      if (DoneE) done_cnt++;
      if (BusyE) busy_cnt++;
    end
    check("startflush_no_done", 32'(done_cnt), 32'd0);
    check("startflush_no_busy", 32'(busy_cnt), 32'd0);
    check("startflush_result", ResultE, 32'd0);

    // Directed operations
    run_op("mul_7_neg3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_neg1_2", 3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op("div_neg7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_neg7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    run_op("divu_by_zero", 3'd5, 32'h1234, 32'd0);
    run_op("rem_by_zero", 3'd6, 32'h1234, 32'd0);
    run_op("div_overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush mid-divide, then a fresh MUL
    prev_res = ResultE;
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b0; MulDivOpE = 3'd5; SrcAE = $urandom; SrcBE = 32'd7;
    #1;
    done_cnt = 0; done_at = 0; got_res = '0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      StartE = (k == 12);
      FlushE = (k == 10);
      if (k == 12) begin MulDivOpE = 3'd0; SrcAE = 32'd3; SrcBE = 32'd5; end
      #1;
      if (k == 11) check("flush_busy_low", 32'(BusyE), 32'd0);
      if (k == 12) check("flush_restart_busy", 32'(BusyE), 32'd1);
      if (k == 44) check("flush_result_kept", ResultE, prev_res);
      if (DoneE) begin
        done_cnt++;
        if (done_at == 0) begin done_at = k; got_res = ResultE; end
      end
    end
    check("flush_done_count", 32'(done_cnt), 32'd1);
    check("flush_done_cycle", 32'(done_at), 32'd45);
    check("flush_mul_result", got_res, 32'd15);

    // Reset in the middle of CALC
    @(negedge clk);
    StartE = 1'b1; MulDivOpE = 3'd5; SrcAE = 32'hDEAD_BEEF; SrcBE = 32'd3;
    #1;
    done_cnt = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      StartE = 1'b0;
      rst    = (k == 5);
      #1;
      if (k == 6) begin
        check("midreset_busy", 32'(BusyE), 32'd0);
        check("midreset_done", 32'(DoneE), 32'd0);
        check("midreset_result", ResultE, 32'd0);
      end
      if (DoneE) done_cnt++;
    end
    check("midreset_no_done", 32'(done_cnt), 32'd0);

    // Randomized operations against the reference
    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick(), pick());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
